// File: rtl/beta_alu_stage_mc.sv
// Beta ALU pipeline stage with a multi-cycle multiply.
// Holds pc/a/b/d/ir; yout is combinational except MUL, which is gated by cnt.
module beta_alu_stage_mc #(
  parameter int          WIDTH   = 32,
  parameter int          MUL_LAT = 4,
  parameter logic [31:0] NOP_IR  = 32'h83FFFFFF,
  parameter logic [31:0] BNE_IR  = 32'h7BDFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       irsrc,
  input  logic             stall_in,
  input  logic             kill,
  input  logic [WIDTH-1:0] pcin,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic [WIDTH-1:0] din,
  input  logic [31:0]      irin,
  output logic [WIDTH-1:0] pcout,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] yout,
  output logic [31:0]      irout,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE
  } state_t;

  logic [WIDTH-1:0] pc, a, b, d;
  logic [WIDTH-1:0] prod, res;
  logic [31:0]      ir, ir_nxt, ir_sel;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [SW-1:0]    sh;
  logic [3:0]       fn;
  logic             is_mul;
  logic             advance;
  state_t           state;

  always_comb begin
    fn = ir[29:26];
    if (ir[31:30] == 2'b01)
      fn = (ir[28:26] == 3'b111) ? 4'b0111 : 4'b0000;
  end

  assign is_mul  = (fn == 4'b0010);
  assign busy    = (state == MULT);
  assign advance = !stall_in && !busy && !kill;

  // With MUL_LAT==1 a multiply never leaves IDLE.
  always_comb begin
    state = IDLE;
    if (is_mul && MUL_LAT > 1)
      state = (cnt == LAST) ? DONE : MULT;
  end

  always_comb begin
    unique case (irsrc)
      2'd0:    ir_sel = irin;
      2'd1:    ir_sel = BNE_IR;
      default: ir_sel = NOP_IR;
    endcase
  end

  always_comb begin
    ir_nxt  = ir;
    cnt_nxt = cnt;
    if (kill) begin
      ir_nxt  = NOP_IR;
      cnt_nxt = '0;
    end else if (advance) begin
      ir_nxt  = ir_sel;
      cnt_nxt = '0;
    end else if (busy) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc  <= '0;
      a   <= '0;
      b   <= '0;
      d   <= '0;
      ir  <= NOP_IR;
      cnt <= '0;
    end else begin
      ir  <= ir_nxt;
      cnt <= cnt_nxt;
      if (advance) begin
        pc <= pcin;
        a  <= ain;
        b  <= bin;
        d  <= din;
      end
    end
  end

  assign sh   = b[SW-1:0];
  assign prod = a * b;

  always_comb begin
    res = '0;
    unique case (fn)
      4'b0000: res = a + b;
      4'b0001: res = a - b;
      4'b0010: res = (state == MULT) ? '0 : prod;
      4'b0011: res = '0;
      4'b0100: res[0] = (a == b);
      4'b0101: res[0] = ($signed(a) < $signed(b));
      4'b0110: res[0] = ($signed(a) <= $signed(b));
      4'b0111: res = a;
      4'b1000: res = a & b;
      4'b1001: res = a | b;
      4'b1010: res = a ^ b;
      4'b1011: res = ~(a ^ b);
      4'b1100: res = a << sh;
      4'b1101: res = a >> sh;
      4'b1110: res = $signed(a) >>> sh;
      default: res = a;
    endcase
  end

  assign yout  = res;
  assign pcout = pc;
  assign dout  = d;
  assign irout = ir;

endmodule

// File: tb/tb_beta_alu_stage_mc.sv
// Scoreboard bench for beta_alu_stage_mc (WIDTH=8, MUL_LAT=4).
// Driver queues what the stage should hold; a negedge monitor compares.
module tb_beta_alu_stage_mc;

  localparam int W   = 8;
  localparam int LAT = 4;
  localparam logic [31:0] NOP = 32'h83FFFFFF;
  localparam logic [31:0] BNE = 32'h7BDFFFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   irsrc = 2'd0;
  logic         stall_in = 1'b0;
  logic         kill = 1'b0;
  logic [W-1:0] pcin = '0, ain = '0, bin = '0, din = '0;
  logic [31:0]  irin = '0;
  logic [W-1:0] pcout, dout, yout;
  logic [31:0]  irout;
  logic         busy;

  beta_alu_stage_mc #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .irsrc(irsrc),
    .stall_in(stall_in), .kill(kill),
    .pcin(pcin), .ain(ain), .bin(bin), .din(din),
    .irin(irin), .pcout(pcout), .dout(dout),
    .yout(yout), .irout(irout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int           cyc;
    logic [W-1:0] pc, a, b, d;
    logic [31:0]  ir;
  } ent_t;

  ent_t exp_q[$];
  ent_t last;
  ent_t cur;
  int   errors = 0;
  int   checks = 0;
  int   since = 0;
  bit   have = 0;

  function automatic int fn_of(logic [31:0] ir);
    if (ir[31:30] == 2'b01)
      return (ir[28:26] == 3'b111) ? 7 : 0;
    return int'(ir[29:26]);
  endfunction

  function automatic logic [W-1:0] ref_y(logic [31:0] ir,
                                         logic [W-1:0] a,
                                         logic [W-1:0] b, int t);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int sh = ub % W;
    int r  = 0;
    case (fn_of(ir))
      0:  r = ua + ub;
      1:  r = ua - ub;
      2:  r = (t >= LAT - 1) ? ua * ub : 0;
      3:  r = 0;
      4:  r = (ua == ub) ? 1 : 0;
      5:  r = (sa < sb) ? 1 : 0;
      6:  r = (sa <= sb) ? 1 : 0;
      8:  r = ua & ub;
      9:  r = ua | ub;
      10: r = ua ^ ub;
      11: r = ~(ua ^ ub);
      12: r = ua * (1 << sh);
      13: r = ua / (1 << sh);
      14: r = sa >>> sh;
      default: r = ua;
    endcase
    return W'(r);
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h",
               nm, cyc_n, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n) begin
      cur   = exp_q.pop_front();
      since = 0;
      have  = 1;
    end else if (have) begin
      since++;
    end
    if (have) begin
      chk("busy", {31'd0, busy},
          {31'd0, fn_of(cur.ir) == 2 && since < LAT - 1});
      chk("yout", {24'd0, yout},
          {24'd0, ref_y(cur.ir, cur.a, cur.b, since)});
      chk("irout", irout, cur.ir);
      chk("pcout", {24'd0, pcout}, {24'd0, cur.pc});
      chk("dout", {24'd0, dout}, {24'd0, cur.d});
    end
  end

  task automatic step(input logic r, input logic k, input logic st,
                      input logic [1:0] src, input logic [31:0] ir,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] pc, input logic [W-1:0] d);
    ent_t e;
    @(posedge clk);
    #1;
    rst_n = r; kill = k; stall_in = st; irsrc = src;
    irin = ir; ain = a; bin = b; pcin = pc; din = d;
    e.cyc = cyc_n + 1;
    if (!r) begin
      e.pc = '0; e.a = '0; e.b = '0; e.d = '0; e.ir = NOP;
      exp_q.push_back(e);
      last = e;
    end else if (k) begin
      e.pc = last.pc; e.a = last.a; e.b = last.b; e.d = last.d;
      e.ir = NOP;
      exp_q.push_back(e);
      last = e;
    end else if (!st && !busy) begin
      e.pc = pc; e.a = a; e.b = b; e.d = d;
      e.ir = (src == 2'd0) ? ir : (src == 2'd1) ? BNE : NOP;
      exp_q.push_back(e);
      last = e;
    end
  endtask

  task automatic run(input int n, input logic st, input logic [31:0] ir,
                     input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, st, 2'd0, ir, a, b, 8'h11, 8'h22);
  endtask

  initial begin
    logic [31:0] ir;
    logic [1:0]  src;
    step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    step(1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'h80000000, 8'd5, 8'd7, 8'h04, 8'h33);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'h88000000, 8'd6, 8'd7, 8'h08, 8'h44);
    run(4, 1'b0, 32'h84000000, 8'd9, 8'd3);
    run(3, 1'b1, 32'h80000000, 8'd1, 8'd1);
    step(1'b1, 1'b0, 1'b0, 2'd1, 32'h80000000, 8'd2, 8'd3, 8'h0c, 8'h01);
    step(1'b1, 1'b0, 1'b0, 2'd2, 32'h80000000, 8'd2, 8'd3, 8'h10, 8'h02);
    step(1'b1, 1'b0, 1'b1, 2'd1, 32'h80000000, 8'd2, 8'd3, 8'h14, 8'h03);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'h88000000, 8'd6, 8'd7, 8'h18, 8'h04);
    run(1, 1'b0, 32'h80000000, 8'd1, 8'd2);
    step(1'b1, 1'b1, 1'b0, 2'd0, 32'h80000000, 8'd1, 8'd2, 8'h1c, 8'h05);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'hB8000000, 8'hF0, 8'd4, 8'h20, 8'h06);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'h94000000, 8'h80, 8'h01, 8'h24, 8'h07);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'h80000000, 8'hFF, 8'h01, 8'h28, 8'h08);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'h88000000, 8'd13, 8'd11, 8'h2c, 8'h09);
    run(1, 1'b1, 32'h80000000, 8'd1, 8'd2);
    step(1'b0, 1'b0, 1'b1, 2'd0, 32'h80000000, 8'd1, 8'd2, 8'h30, 8'h0a);
    step(1'b1, 1'b0, 1'b0, 2'd0, 32'h7C000000, 8'h5a, 8'd2, 8'h34, 8'h0b);

    for (int i = 0; i < 1500; i++) begin
      ir = $urandom;
      if ($urandom_range(0, 3) == 0) ir[31:26] = 6'b100010;
      src = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      step($urandom_range(0, 149) != 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) == 0,
           src, ir,
           ($urandom_range(0, 3) == 0) ? 8'h80 : W'($urandom),
           W'($urandom), W'($urandom), W'($urandom));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/beta_alu_stage_mc.md
BETA_ALU_STAGE_MC -- requirements
Module: beta_alu_stage_mc

Interface
REQ-001 Parameter WIDTH, 32, datapath width of A/B/D/PC/Y; legal values 8..64.
REQ-002 Parameter MUL_LAT, 4, cycles a multiply occupies the stage; legal values 1..16.
REQ-003 Parameter NOP_IR, 32'h83FFFFFF, instruction word injected on flush or kill.
REQ-004 Parameter BNE_IR, 32'h7BDFFFFF, instruction word injected on exception.
REQ-005 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port rst_n  input  1  reset; one clock, reset is synchronous and active-low.
REQ-007 Port irsrc  input  2  instruction source: 0 = irin, 1 = BNE_IR, 2/3 = NOP_IR.
REQ-008 Port stall_in  input  1  downstream not ready; stage holds when high.
REQ-009 Port kill  input  1  squash the held instruction.
REQ-010 Ports pcin, ain, bin, din  input  WIDTH each  upstream operands.
REQ-011 Port irin  input  32  upstream instruction.
REQ-012 Ports pcout, dout, yout  output  WIDTH each  registered PC, registered D, ALU result.
REQ-013 Port irout  output  32  registered instruction.
REQ-014 Port busy  output  1  stage cannot accept; upstream holds.

Function
REQ-015 advance = !stall_in && !busy && !kill; pc/a/b/d SHALL load from inputs only when advance=1, else hold.
REQ-016 On advance, ir SHALL load per irsrc; irsrc is ignored when advance=0 (upstream re-presents).
REQ-017 kill=1 SHALL set ir<=NOP_IR and cnt<=0 next edge, overriding advance and stall; the incoming instruction is discarded.
REQ-018 AluFn SHALL be ir[29:26], except when ir[31:30]==01: LDR (ir[28:26]==111) -> 0111, others -> 0000.
REQ-019 AluFn map: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 CMPEQ, 0101 CMPLT (signed), 0110 CMPLE (signed), 0111/1111 pass A, 1000 AND, 1001 OR, 1010 XOR, 1011 XNOR, 1100 SHL, 1101 SHR, 1110 SRA.
REQ-020 Arithmetic is modulo 2^WIDTH; compares yield 1 or 0, zero-extended; shift amount = b[clog2(WIDTH)-1:0]; DIV yields 0.
REQ-021 Non-MUL results SHALL be combinational from held a, b, ir.
REQ-022 MUL FSM, counter cnt (0..MUL_LAT-1): IDLE (non-MUL held or cnt==0 with MUL_LAT==1); MULT (MUL held, cnt<MUL_LAT-1); DONE (MUL held, cnt==MUL_LAT-1).
REQ-023 busy = (AluFn==MUL) && (cnt < MUL_LAT-1); while busy, cnt increments each edge and all pipeline registers hold.
REQ-024 yout SHALL be 0 in MULT and the low WIDTH bits of a*b in DONE; DONE holds under stall_in until advance.
REQ-025 On advance, cnt<=0; back-to-back MULs each take MUL_LAT cycles.
REQ-026 MUL_LAT==1: busy never asserts; MUL completes in one cycle like other ops.
REQ-027 stall_in during MULT SHALL NOT stop cnt; only advance is blocked.
REQ-028 pcout, irout, dout SHALL equal held pc, ir, d.

Reset
REQ-029 rst_n low at an edge: ir<=NOP_IR, pc/a/b/d<=0, cnt<=0; overrides kill, stall, busy.
REQ-030 Reset mid-multiply SHALL abort it; busy=0 and yout=0 (ADD of zeros) the cycle after.
REQ-031 Out of reset irout=NOP_IR, pcout=dout=yout=0, busy=0.

Verification
REQ-032 Reset, then irsrc=0, irin=ADD (0x80000000 class), ain=5, bin=7 -> next cycle yout=12, irout=irin, busy=0.
REQ-033 MUL_LAT=4, ain=6, bin=7, MUL loaded -> busy high 3 cycles, yout=0 then 42 in cycle 4; next instruction captured cycle 5.
REQ-034 irsrc=1 on advance -> irout=BNE_IR; irsrc=2 -> irout=NOP_IR; stall_in=1 with irsrc=1 -> irout unchanged.
REQ-035 kill asserted in MULT cnt=1 -> next cycle irout=NOP_IR, busy=0, cnt=0.
REQ-036 WIDTH=8: ain=0xF0, bin=4, SRA -> yout=0xFF; CMPLT 0x80 vs 0x01 -> 1; ADD 0xFF+0x01 -> 0x00.
REQ-037 rst_n low during MULT with stall_in=1 -> next cycle irout=NOP_IR, busy=0, all outputs 0.
